// File: rtl/par_checking_sink_if.sv
// Local-port link between a NoC router's tx_l port and the checking sink.
//   data  : flit {hdr, payload, addr}, addr in the low `ADDR_SZ bits
//   valid : data is valid this cycle
//   busy  : sink refuses; a transfer happens on posedge when valid && !busy
// Modports: master (router side drives data/valid), slave (sink drives busy).

`ifndef HDR_SZ
`define HDR_SZ 2
`endif
`ifndef PL_SZ
`define PL_SZ 16
`endif
`ifndef ADDR_SZ
`define ADDR_SZ 3
`endif
`ifndef NUM_NODES
`define NUM_NODES 8
`endif

interface par_checking_sink_if;
  localparam int unsigned FlitW = `HDR_SZ + `PL_SZ + `ADDR_SZ;

  logic [FlitW-1:0] data;
  logic             valid;
  logic             busy;

  modport master (output data, output valid, input busy);
  modport slave  (input data, input valid, output busy);
endinterface

// File: rtl/par_checking_sink.sv
// par_checking_sink: local-port receiver/checker for one NoC node.
// Buffers incoming flits in a small FIFO, drains them at a rate throttled by an LFSR against
// SINK_HOSP, and checks each popped flit's destination address and per-source sequence number.
//
// Parameters:
//   ID          node address compared against the flit addr field
//   SINK_HOSP   drain hospitality 0-255; pop allowed when lfsr < SINK_HOSP (255 = always)
//   FIFO_DEPTH  buffer entries, power of 2, >= 2
//   SEQ_W       sequence-number width, taken from payload[SEQ_W-1:0]
// Ports:
//   clk           node clock
//   reset         asynchronous, active-low
//   link          slave side of par_checking_sink_if (data, valid in; busy out)
//   rx_cnt        flits popped and checked (saturating)
//   addr_err_cnt  popped flits whose addr != ID (saturating)
//   seq_err_cnt   popped flits with an unexpected sequence number (saturating)
//   overflow      sticky; a write was attempted while the FIFO was full
// Configuration macro:
//   SINK_SEQ_CHECK_EN  when defined, the per-source expected-sequence table is built and
//                      seq_err_cnt is live; otherwise seq_err_cnt is tied to zero.

`ifndef HDR_SZ
`define HDR_SZ 2
`endif
`ifndef PL_SZ
`define PL_SZ 16
`endif
`ifndef ADDR_SZ
`define ADDR_SZ 3
`endif
`ifndef NUM_NODES
`define NUM_NODES 8
`endif

module par_checking_sink #(
  parameter int unsigned ID         = 0,
  parameter int unsigned SINK_HOSP  = 255,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned SEQ_W      = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  par_checking_sink_if.slave   link,
  output logic [15:0]          rx_cnt,
  output logic [15:0]          addr_err_cnt,
  output logic [15:0]          seq_err_cnt,
  output logic                 overflow
);

  localparam int unsigned FlitW = `HDR_SZ + `PL_SZ + `ADDR_SZ;
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StCheck, StHold} state_e;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // ---------------------------------------------------------------------------------------------
  // Storage and state
  // ---------------------------------------------------------------------------------------------
  logic [FlitW-1:0] fifo_q [FIFO_DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             rst_q;
  logic [7:0]       lfsr_q, lfsr_d;
  state_e           state_q, state_d;
  logic [15:0]      rx_cnt_q, rx_cnt_d;
  logic [15:0]      addr_err_q, addr_err_d;
  logic             overflow_q, overflow_d;

  logic full, empty, push, pop, may_pop;
  logic [FlitW-1:0]    head;
  logic [`ADDR_SZ-1:0] head_addr;
  logic [`PL_SZ-1:0]   head_pl;

  assign full  = (count_q == CntW'(FIFO_DEPTH));
  assign empty = (count_q == '0);

  // rst_q keeps busy high for the first cycle after reset release.
  assign link.busy = full | rst_q;
  assign push      = link.valid & ~link.busy;

  assign head      = fifo_q[rd_ptr_q];
  assign head_addr = head[`ADDR_SZ-1:0];
  assign head_pl   = head[`ADDR_SZ +: `PL_SZ];

  // Fibonacci LFSR, polynomial x^8 + x^6 + x^5 + x^4 + 1.
  assign lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign may_pop = (SINK_HOSP == 255) || (32'(lfsr_q) < SINK_HOSP);

  // ---------------------------------------------------------------------------------------------
  // Drain FSM
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (!empty) state_d = StCheck;
      end
      StCheck: begin
        if (may_pop) begin
          // Stay in StCheck while work remains so back-to-back flits drain at 1/cycle.
          state_d = (count_q == CntW'(1) && !push) ? StIdle : StCheck;
        end else begin
          state_d = StHold;
        end
      end
      StHold: begin
        state_d = StCheck;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pop = 1'b0;
    if (state_q == StCheck && may_pop) pop = 1'b1;
  end

  // ---------------------------------------------------------------------------------------------
  // FIFO bookkeeping
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (link.valid & full);
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= link.data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rst_q      <= 1'b1;
      lfsr_q     <= 8'hA5;
      rx_cnt_q   <= '0;
      addr_err_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rst_q      <= 1'b0;
      lfsr_q     <= lfsr_d;
      rx_cnt_q   <= rx_cnt_d;
      addr_err_q <= addr_err_d;
      overflow_q <= overflow_d;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Checking on pop
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    rx_cnt_d   = rx_cnt_q;
    addr_err_d = addr_err_q;
    if (pop) begin
      rx_cnt_d = sat_inc(rx_cnt_q);
      if (head_addr != `ADDR_SZ'(ID)) addr_err_d = sat_inc(addr_err_q);
    end
  end

`ifdef SINK_SEQ_CHECK_EN
  logic [SEQ_W-1:0]    exp_q [`NUM_NODES];
  logic [SEQ_W-1:0]    exp_d [`NUM_NODES];
  logic [15:0]         seq_err_q, seq_err_d;
  logic [`ADDR_SZ-1:0] src;
  logic [SEQ_W-1:0]    seq;
  logic                src_ok;

  assign src    = head_pl[`PL_SZ-1 -: `ADDR_SZ];
  assign seq    = head_pl[SEQ_W-1:0];
  // Sources with no table entry are not sequence-checked.
  assign src_ok = (32'(src) < `NUM_NODES);

  always_comb begin
    exp_d     = exp_q;
    seq_err_d = seq_err_q;
    if (pop && src_ok) begin
      if (seq != exp_q[src]) seq_err_d = sat_inc(seq_err_q);
      // Resync to the received number so a single gap costs one error.
      exp_d[src] = seq + SEQ_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < `NUM_NODES; i++) exp_q[i] <= '0;
      seq_err_q <= '0;
    end else begin
      exp_q     <= exp_d;
      seq_err_q <= seq_err_d;
    end
  end

  assign seq_err_cnt = seq_err_q;
`else
  assign seq_err_cnt = 16'd0;
`endif

  // Header and the middle payload bits carry nothing this block checks.
  logic unused_head;
  assign unused_head = ^head;

  assign rx_cnt       = rx_cnt_q;
  assign addr_err_cnt = addr_err_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_par_checking_sink.sv
// Self-checking bench for par_checking_sink. Three instances share clock and reset:
//   dut_a: SINK_HOSP=255 (always drains), dut_b: SINK_HOSP=0 (never drains),
//   dut_c: SINK_HOSP=128 (throttled drain, used with randomized traffic).

`ifndef HDR_SZ
`define HDR_SZ 2
`endif
`ifndef PL_SZ
`define PL_SZ 16
`endif
`ifndef ADDR_SZ
`define ADDR_SZ 3
`endif
`ifndef NUM_NODES
`define NUM_NODES 8
`endif

module tb_par_checking_sink;
  localparam int HD   = `HDR_SZ;
  localparam int PL   = `PL_SZ;
  localparam int AD   = `ADDR_SZ;
  localparam int W    = HD + PL + AD;
  localparam int SEQW = 4;
  localparam int MYID = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  par_checking_sink_if if_a ();
  par_checking_sink_if if_b ();
  par_checking_sink_if if_c ();

  logic [15:0] rx_a, ae_a, se_a, rx_b, ae_b, se_b, rx_c, ae_c, se_c;
  logic        ov_a, ov_b, ov_c;

  par_checking_sink #(.ID(MYID), .SINK_HOSP(255), .FIFO_DEPTH(4), .SEQ_W(SEQW)) dut_a (
    .clk(clk), .reset(reset), .link(if_a.slave),
    .rx_cnt(rx_a), .addr_err_cnt(ae_a), .seq_err_cnt(se_a), .overflow(ov_a));
  par_checking_sink #(.ID(MYID), .SINK_HOSP(0), .FIFO_DEPTH(4), .SEQ_W(SEQW)) dut_b (
    .clk(clk), .reset(reset), .link(if_b.slave),
    .rx_cnt(rx_b), .addr_err_cnt(ae_b), .seq_err_cnt(se_b), .overflow(ov_b));
  par_checking_sink #(.ID(MYID), .SINK_HOSP(128), .FIFO_DEPTH(4), .SEQ_W(SEQW)) dut_c (
    .clk(clk), .reset(reset), .link(if_c.slave),
    .rx_cnt(rx_c), .addr_err_cnt(ae_c), .seq_err_cnt(se_c), .overflow(ov_c));

  int checks = 0;
  int errors = 0;

`ifdef SINK_SEQ_CHECK_EN
  localparam bit SeqOn = 1'b1;
`else
  localparam bit SeqOn = 1'b0;
`endif

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  function automatic logic [W-1:0] make_flit(input int addr, input int src, input int seq);
    logic [PL-1:0] pl;
    logic [HD-1:0] h;
    logic [AD-1:0] a;
    logic [AD-1:0] s;
    logic [SEQW-1:0] q;
    pl = PL'($urandom);
    h  = HD'($urandom);
    a  = AD'(addr);
    s  = AD'(src);
    q  = SEQW'(seq);
    pl[PL-1 -: AD] = s;
    pl[SEQW-1:0]   = q;
    return {h, pl, a};
  endfunction

  function automatic logic get_busy(input int which);
    case (which)
      0:       return if_a.busy;
      1:       return if_b.busy;
      default: return if_c.busy;
    endcase
  endfunction

  task automatic drive(input int which, input logic [W-1:0] d, input logic v);
    case (which)
      0:       begin if_a.data = d; if_a.valid = v; end
      1:       begin if_b.data = d; if_b.valid = v; end
      default: begin if_c.data = d; if_c.valid = v; end
    endcase
  endtask

  task automatic idle_all();
    if_a.valid = 1'b0;
    if_b.valid = 1'b0;
    if_c.valid = 1'b0;
  endtask

  // Offers a flit only while busy is low, so a full FIFO is never written; gives up after a bound.
  task automatic send(input int which, input logic [W-1:0] d, input int bound, output bit ok);
    int n;
    n  = 0;
    ok = 1'b0;
    while (get_busy(which) && n < bound) begin
      drive(which, d, 1'b0);
      @(negedge clk);
      n++;
    end
    if (!get_busy(which)) begin
      drive(which, d, 1'b1);
      @(negedge clk);
      ok = 1'b1;
    end else begin
      drive(which, d, 1'b0);
    end
  endtask

  task automatic do_reset();
    idle_all();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle_all();
    #1 reset = 1'b0;
    #1;
    checks++;
    if (if_a.busy !== 1'b1 || rx_a !== 16'd0 || ae_a !== 16'd0 || se_a !== 16'd0) begin
      errors++;
      $display("FAIL reset_hold: busy=%b rx=%0d ae=%0d se=%0d, required busy=1 counters 0",
               if_a.busy, rx_a, ae_a, se_a);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (if_a.busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_busy: busy=%b, required 1", if_a.busy);
    end
    @(negedge clk);
    checks++;
    if (if_a.busy !== 1'b0 || if_b.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy_drop: busy_a=%b busy_b=%b, required 0", if_a.busy, if_b.busy);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (rx_a !== 16'd0 || ae_a !== 16'd0 || se_a !== 16'd0 || ov_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_counters: rx=%0d ae=%0d se=%0d ov=%b, required all 0",
               rx_a, ae_a, se_a, ov_a);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] snap [8];
    bit ok;
    int busy_seen;
    do_reset();
    busy_seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (if_a.busy !== 1'b0) busy_seen++;
      send(0, make_flit(MYID, 2, i), 4, ok);
      snap[i] = rx_a;
    end
    idle_all();
    repeat (4) @(negedge clk);
    checks++;
    if (busy_seen != 0) begin
      errors++;
      $display("FAIL b2b_busy: busy high %0d times, required 0", busy_seen);
    end
    checks++;
    if (snap[1] !== 16'd0 || snap[2] !== 16'd1) begin
      errors++;
      $display("FAIL b2b_latency: rx after 2nd/3rd edge %0d/%0d, required 0/1", snap[1], snap[2]);
    end
    checks++;
    if (snap[7] !== 16'd6) begin
      errors++;
      $display("FAIL b2b_throughput: rx after 8th write %0d, required 6", snap[7]);
    end
    checks++;
    if (rx_a !== 16'd8 || ae_a !== 16'd0 || se_a !== 16'd0) begin
      errors++;
      $display("FAIL b2b_counters: rx=%0d ae=%0d se=%0d, required 8/0/0", rx_a, ae_a, se_a);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int acc;
    do_reset();
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      send(1, make_flit(MYID, 3, i), 10, ok);
      if (ok) acc++;
    end
    idle_all();
    @(negedge clk);
    checks++;
    if (acc != 4 || if_b.busy !== 1'b1) begin
      errors++;
      $display("FAIL bp_accept: accepted=%0d busy=%b, required 4/1", acc, if_b.busy);
    end
    checks++;
    if (rx_b !== 16'd0 || ov_b !== 1'b0) begin
      errors++;
      $display("FAIL bp_no_drain: rx=%0d ov=%b, required 0/0", rx_b, ov_b);
    end
    if_b.data  = make_flit(MYID, 3, 9);
    if_b.valid = 1'b1;
    @(negedge clk);
    if_b.valid = 1'b0;
    @(negedge clk);
    checks++;
    if (ov_b !== 1'b1) begin
      errors++;
      $display("FAIL bp_overflow: ov=%b, required 1", ov_b);
    end
  endtask

  task automatic test_seq();
    int srcs [6] = '{1, 5, 1, 5, 1, 1};
    int seqs [6] = '{0, 0, 1, 1, 3, 4};
    bit ok;
    do_reset();
    for (int i = 0; i < 6; i++) send(0, make_flit(MYID, srcs[i], seqs[i]), 8, ok);
    idle_all();
    repeat (5) @(negedge clk);
    checks++;
    if (rx_a !== 16'd6 || ae_a !== 16'd0) begin
      errors++;
      $display("FAIL seq_rx: rx=%0d ae=%0d, required 6/0", rx_a, ae_a);
    end
    checks++;
    if (se_a !== (SeqOn ? 16'd1 : 16'd0)) begin
      errors++;
      $display("FAIL seq_err: se=%0d, required %0d", se_a, SeqOn ? 1 : 0);
    end
  endtask

  task automatic test_addr_and_async_reset();
    bit ok;
    int acc;
    do_reset();
    send(0, make_flit(7, 2, 0), 8, ok);
    idle_all();
    repeat (4) @(negedge clk);
    checks++;
    if (ae_a !== 16'd1 || rx_a !== 16'd1 || se_a !== 16'd0) begin
      errors++;
      $display("FAIL addr_err: ae=%0d rx=%0d se=%0d, required 1/1/0", ae_a, rx_a, se_a);
    end
    for (int i = 0; i < 3; i++) send(1, make_flit(MYID, 6, i), 8, ok);
    idle_all();
    #2 reset = 1'b0;
    #1;
    checks++;
    if (rx_a !== 16'd0 || ae_a !== 16'd0 || if_a.busy !== 1'b1 || if_b.busy !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: rx=%0d ae=%0d busy_a=%b busy_b=%b, required 0/0/1/1",
               rx_a, ae_a, if_a.busy, if_b.busy);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      send(1, make_flit(MYID, 6, i), 4, ok);
      if (ok) acc++;
    end
    idle_all();
    checks++;
    if (acc != 4 || if_b.busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_flush: accepted=%0d busy=%b, required 4/1", acc, if_b.busy);
    end
  endtask

  task automatic test_random();
    int mexp [`NUM_NODES];
    int m_rx, m_ae, m_se, addr, src, seq, n;
    bit ok;
    do_reset();
    for (int i = 0; i < `NUM_NODES; i++) mexp[i] = 0;
    m_rx = 0; m_ae = 0; m_se = 0;
    for (int i = 0; i < 40; i++) begin
      addr = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : MYID;
      src  = $urandom_range(0, `NUM_NODES - 1);
      seq  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 15) : mexp[src];
      send(2, make_flit(addr, src, seq), 64, ok);
      if (!ok) begin
        checks++;
        errors++;
        $display("FAIL rand_send_timeout: flit %0d not accepted, required acceptance", i);
      end else begin
        m_rx++;
        if (addr != MYID) m_ae++;
        if (seq != mexp[src]) m_se++;
        mexp[src] = (seq + 1) % (1 << SEQW);
      end
      idle_all();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    n = 0;
    while (rx_c != 16'(m_rx) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (rx_c !== 16'(m_rx)) begin
      errors++;
      $display("FAIL rand_rx: rx=%0d, required %0d", rx_c, m_rx);
    end
    checks++;
    if (ae_c !== 16'(m_ae)) begin
      errors++;
      $display("FAIL rand_addr_err: ae=%0d, required %0d", ae_c, m_ae);
    end
    checks++;
    if (se_c !== (SeqOn ? 16'(m_se) : 16'd0)) begin
      errors++;
      $display("FAIL rand_seq_err: se=%0d, required %0d", se_c, SeqOn ? m_se : 0);
    end
    checks++;
    if (ov_c !== 1'b0) begin
      errors++;
      $display("FAIL rand_overflow: ov=%b, required 0", ov_c);
    end
  endtask

  initial begin
    if_a.data = '0; if_b.data = '0; if_c.data = '0;
    idle_all();
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_seq();
    test_addr_and_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
